// File: rtl/redirect_pkg.sv
// Shared types and default vectors for the fetch redirect sequencer.
package redirect_pkg;

  typedef enum logic [1:0] {
    K_BR     = 2'd0,
    K_ERET   = 2'd1,
    K_EXC    = 2'd2,
    K_REFILL = 2'd3
  } redir_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH
  } redir_state_t;

  localparam logic [31:0] DEF_RESET_PC   = 32'hbfc00000;
  localparam logic [31:0] DEF_REFILL_VEC = 32'hbfc00200;
  localparam logic [31:0] DEF_GEN_VEC    = 32'hbfc00380;

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority encoder over the four redirect sources: refill > exception > ERET > branch.
module redirect_prio_enc
  import redirect_pkg::*;
#(
  parameter logic [31:0] REFILL_VEC = DEF_REFILL_VEC,
  parameter logic [31:0] GEN_VEC    = DEF_GEN_VEC
) (
  input  logic        tlb_refill,
  input  logic        excp,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        req,
  output redir_kind_t kind,
  output logic [31:0] target
);

  always_comb begin
    req    = tlb_refill | excp | eret | br_taken;
    kind   = K_BR;
    target = br_target;
    if (tlb_refill) begin
      kind   = K_REFILL;
      target = REFILL_VEC;
    end else if (excp) begin
      kind   = K_EXC;
      target = GEN_VEC;
    end else if (eret) begin
      kind   = K_ERET;
      target = epc;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Redirect sequencer feeding the fetch PC mux: captures, holds and flushes.
// Optional saturating statistics counters are enabled by defining REDIRECT_STATS_EN.
module fetch_redirect_ctrl
  import redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter logic [31:0] REFILL_VEC   = DEF_REFILL_VEC,
  parameter logic [31:0] GEN_VEC      = DEF_GEN_VEC,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        tlb_refill,
  input  logic        excp,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [1:0]  redir_kind,
  output logic        flush_fe,
  output logic        flush_de,
  output logic        flush_exe,
  output logic        busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0] stat_excp,
  output logic [15:0] stat_br,
  output logic [15:0] stat_stall
`endif
);

  redir_state_t state;
  redir_kind_t  kind_q;
  logic [3:0]   flush_cnt;
  logic         flush_q;
  logic         in_flush;
  logic         req;
  redir_kind_t  req_kind;
  logic [31:0]  req_pc;
  logic         preempt;
  logic         accept;

  assign in_flush = (state == S_FLUSH);

  // ERET and branch requests during a flush belong to squashed instructions.
  redirect_prio_enc #(
    .REFILL_VEC (REFILL_VEC),
    .GEN_VEC    (GEN_VEC)
  ) u_prio (
    .tlb_refill (tlb_refill),
    .excp       (excp),
    .eret       (eret & ~in_flush),
    .epc        (epc),
    .br_taken   (br_taken & ~in_flush),
    .br_target  (br_target),
    .req        (req),
    .kind       (req_kind),
    .target     (req_pc)
  );

  assign preempt = req && (req_kind > kind_q);
  assign accept  = (state == S_ISSUE) && !stall && !preempt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      kind_q      <= K_BR;
      flush_cnt   <= '0;
      flush_q     <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= RESET_PC;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state       <= S_ISSUE;
            kind_q      <= req_kind;
            redir_pc    <= req_pc;
            redir_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (preempt) begin
            kind_q   <= req_kind;
            redir_pc <= req_pc;
          end else if (!stall) begin
            if (kind_q != K_BR) begin
              state       <= S_FLUSH;
              flush_cnt   <= 4'(FLUSH_CYCLES);
              flush_q     <= 1'b1;
              redir_valid <= 1'b0;
            end else if (req) begin
              kind_q   <= req_kind;
              redir_pc <= req_pc;
            end else begin
              state       <= S_IDLE;
              redir_valid <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (req) begin
            state       <= S_ISSUE;
            kind_q      <= req_kind;
            redir_pc    <= req_pc;
            redir_valid <= 1'b1;
            flush_q     <= 1'b0;
            flush_cnt   <= '0;
          end else if (flush_cnt == 4'd1) begin
            state     <= S_IDLE;
            flush_q   <= 1'b0;
            flush_cnt <= '0;
            busy      <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign redir_kind = kind_q;
  assign flush_fe   = flush_q;
  assign flush_de   = flush_q;
  assign flush_exe  = flush_q;

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_excp  <= '0;
      stat_br    <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && kind_q >= K_EXC && stat_excp != '1) stat_excp <= stat_excp + 16'd1;
      if (accept && kind_q == K_BR && stat_br != '1) stat_br <= stat_br + 16'd1;
      if (state == S_ISSUE && stall && stat_stall != '1) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic.
module tb_fetch_redirect_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, tlb_refill, excp, eret, br_taken;
  logic [31:0] epc, br_target;
  logic        redir_valid, flush_fe, flush_de, flush_exe, busy;
  logic [31:0] redir_pc;
  logic [1:0]  redir_kind;
`ifdef REDIRECT_STATS_EN
  logic [15:0] stat_excp, stat_br, stat_stall;
`endif

  fetch_redirect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .tlb_refill  (tlb_refill),
    .excp        (excp),
    .eret        (eret),
    .epc         (epc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_kind  (redir_kind),
    .flush_fe    (flush_fe),
    .flush_de    (flush_de),
    .flush_exe   (flush_exe),
    .busy        (busy)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_excp   (stat_excp),
    .stat_br     (stat_br),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one pending redirect plus a count of flush cycles still owed.
  bit          m_valid;
  logic [31:0] m_pc;
  int          m_kind;
  int          m_flush;
  int          m_se, m_sb, m_ss;

  task automatic model_reset();
    m_valid = 0; m_pc = 32'hbfc00000; m_kind = 0; m_flush = 0;
    m_se = 0; m_sb = 0; m_ss = 0;
  endtask

  task automatic model_step();
    bit          fl, r;
    int          k;
    logic [31:0] t;
    fl = (m_flush > 0);
    r  = tlb_refill | excp | (!fl & (eret | br_taken));
    k  = tlb_refill ? 3 : excp ? 2 : eret ? 1 : 0;
    t  = (k == 3) ? 32'hbfc00200 : (k == 2) ? 32'hbfc00380 : (k == 1) ? epc : br_target;
    if (fl) begin
      if (tlb_refill | excp) begin
        m_flush = 0; m_valid = 1; m_kind = k; m_pc = t;
      end else m_flush--;
    end else if (m_valid) begin
      if (stall && m_ss < 65535) m_ss++;
      if (r && k > m_kind) begin
        m_kind = k; m_pc = t;
      end else if (!stall) begin
        if (m_kind >= 2 && m_se < 65535) m_se++;
        if (m_kind == 0 && m_sb < 65535) m_sb++;
        if (m_kind >= 1) begin
          m_valid = 0; m_flush = FC;
        end else if (r) begin
          m_kind = k; m_pc = t;
        end else m_valid = 0;
      end
    end else if (r) begin
      m_valid = 1; m_kind = k; m_pc = t;
    end
  endtask

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    chk("redir_valid", 32'(redir_valid), 32'(m_valid));
    chk("redir_pc", redir_pc, m_pc);
    chk("redir_kind", 32'(redir_kind), 32'(m_kind));
    chk("flush_fe", 32'(flush_fe), 32'(m_flush > 0));
    chk("flush_de", 32'(flush_de), 32'(m_flush > 0));
    chk("flush_exe", 32'(flush_exe), 32'(m_flush > 0));
    chk("busy", 32'(busy), 32'(m_valid || m_flush > 0));
`ifdef REDIRECT_STATS_EN
    chk("stat_excp", 32'(stat_excp), 32'(m_se));
    chk("stat_br", 32'(stat_br), 32'(m_sb));
    chk("stat_stall", 32'(stat_stall), 32'(m_ss));
`endif
  end

  // One clock: drive inputs, let the edge happen, advance the model, settle 1 time unit.
  task automatic cyc(input bit s, input bit rf, input bit ex, input bit er, input logic [31:0] ep,
                     input bit br, input logic [31:0] bt);
    stall = s; tlb_refill = rf; excp = ex; eret = er; epc = ep; br_taken = br; br_target = bt;
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
  endtask

  task automatic idle(input bit s);
    cyc(s, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; tlb_refill = 0; excp = 0; eret = 0; br_taken = 0; epc = '0; br_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", redir_pc, 32'hbfc00000);
    chk("rst_valid", 32'(redir_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(0);

    // Branch in IDLE
    cyc(0, 0, 0, 0, 32'h0, 1, 32'h80001000);
    chk("br_valid", 32'(redir_valid), 32'd1);
    chk("br_pc", redir_pc, 32'h80001000);
    chk("br_kind", 32'(redir_kind), 32'd0);
    idle(0);
    chk("br_done_busy", 32'(busy), 32'd0);
    chk("br_no_flush", 32'(flush_fe), 32'd0);

    // Simultaneous exception and branch
    cyc(0, 0, 1, 0, 32'h0, 1, 32'h80001100);
    chk("sim_pc", redir_pc, 32'hbfc00380);
    chk("sim_kind", 32'(redir_kind), 32'd2);
    idle(0);
    chk("sim_flush1", 32'(flush_fe), 32'd1);
    idle(0);
    chk("sim_flush2", 32'(flush_exe), 32'd1);
    idle(0);
    chk("sim_flush_end", 32'(flush_de), 32'd0);
    chk("sim_busy_end", 32'(busy), 32'd0);

    // ERET stalled, preempted by refill in the third stall cycle
    cyc(0, 0, 0, 1, 32'h80002000, 0, 32'h0);
    chk("eret_pc", redir_pc, 32'h80002000);
    chk("eret_kind", 32'(redir_kind), 32'd1);
    idle(1);
    idle(1);
    cyc(1, 1, 0, 0, 32'h0, 0, 32'h0);
    idle(1);
    idle(1);
    chk("pre_valid", 32'(redir_valid), 32'd1);
    chk("pre_pc", redir_pc, 32'hbfc00200);
    chk("pre_kind", 32'(redir_kind), 32'd3);
    idle(0);
    chk("pre_accept_flush", 32'(flush_fe), 32'd1);
    chk("pre_accept_valid", 32'(redir_valid), 32'd0);
    idle(0);
    idle(0);

    // FLUSH filtering
    cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
    idle(0);
    cyc(0, 0, 0, 0, 32'h0, 1, 32'h80003000);
    chk("ff_br_ignored", 32'(redir_valid), 32'd0);
    chk("ff_still_flush", 32'(flush_de), 32'd1);
    cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
    chk("ff_exc_valid", 32'(redir_valid), 32'd1);
    chk("ff_exc_pc", redir_pc, 32'hbfc00380);
    chk("ff_exc_noflush", 32'(flush_exe), 32'd0);
    idle(0);
    idle(0);
    idle(0);
    chk("ff_busy_end", 32'(busy), 32'd0);

    // Asynchronous reset while a stalled redirect is pending
    cyc(1, 0, 0, 1, 32'h80004000, 0, 32'h0);
    idle(1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_valid", 32'(redir_valid), 32'd0);
    chk("ar_pc", redir_pc, 32'hbfc00000);
    chk("ar_kind", 32'(redir_kind), 32'd0);
    idle(1);
    idle(0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("ar_no_replay", 32'(redir_valid), 32'd0);
    end

`ifdef REDIRECT_STATS_EN
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h0, 1, 32'h80005000 + 32'(i * 4));
    idle(0);
    cyc(0, 0, 1, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++) idle(1);
    idle(0);
    chk("st_br", 32'(stat_br), 32'd3);
    chk("st_excp", 32'(stat_excp), 32'd1);
    chk("st_stall", 32'(stat_stall), 32'd4);
    idle(0);
    idle(0);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 99) < 40,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 7,
          $urandom_range(0, 99) < 10, $urandom,
          $urandom_range(0, 99) < 30, $urandom);
    end
    idle(0);
    for (int i = 0; i < FC + 3; i++) idle(0);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencer between redirect sources and the fetch PC register. It collects same-cycle redirect requests from the TLB, exception, ERET and branch logic and resolves them by fixed priority. It holds the winning target until fetch accepts it, then drives a timed flush of the front-end stages after exception and ERET redirects. The next-PC mux consumes `redir_valid`/`redir_pc` in place of its raw exception and branch selects.

## Interface
Parameters:
- `RESET_PC`, default 32'hbfc00000, value of `redir_pc` while reset is asserted and after it deasserts.
- `REFILL_VEC`, default 32'hbfc00200, TLB-refill vector.
- `GEN_VEC`, default 32'hbfc00380, general exception vector.
- `FLUSH_CYCLES`, default 2, length of the flush window; legal range 1..15.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `stall`, in, 1, fetch cannot accept a new PC this cycle.
- `tlb_refill`, in, 1, TLB refill exception request.
- `excp`, in, 1, any other exception request, including the TLB-invalid and TLB-modified classes.
- `eret`, in, 1, ERET request.
- `epc`, in, 32, ERET target.
- `br_taken`, in, 1, taken-branch request.
- `br_target`, in, 32, fully resolved branch target.
- `redir_valid`, out, 1, pending redirect is being offered to fetch.
- `redir_pc`, out, 32, redirect target.
- `redir_kind`, out, 2, kind of the pending redirect: 0 branch, 1 ERET, 2 exception, 3 refill.
- `flush_fe`, `flush_de`, `flush_exe`, out, 1 each, kill the contents of those stages.
- `busy`, out, 1, high whenever the state is not IDLE.

## Operation
- Request priority: refill (3) > exception (2) > ERET (1) > branch (0).
- Target of the winning request:
  - refill → `REFILL_VEC`
  - exception → `GEN_VEC`
  - ERET → `epc`
  - branch → `br_target`
- The target is sampled at capture time. Later changes to `epc` or `br_target` have no effect.

FSM states are IDLE, ISSUE and FLUSH.
- IDLE:
  - Any request: capture target and kind, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - `redir_valid` is 1.
  - A new request with strictly higher priority than the pending kind overwrites target and kind. Equal or lower priority requests are dropped.
  - Acceptance is `!stall` in ISSUE. On acceptance:
    - Kind ≥ 1 → go to FLUSH and load the flush counter with `FLUSH_CYCLES`.
    - Kind 0 with a request present in the same cycle → capture it and stay in ISSUE.
    - Kind 0 with no request → go to IDLE.
  - When acceptance and a higher-priority overwrite occur in the same cycle, the overwrite wins and no acceptance happens.
- FLUSH:
  - All `flush_*` outputs are 1.
  - The counter decrements each cycle; at 1 the FSM returns to IDLE.
  - `br_taken` and `eret` are dropped, because they belong to squashed instructions.
  - `tlb_refill` or `excp` captures the request, ends FLUSH, and moves to ISSUE next cycle.
- Registered outputs, with their values while reset is asserted:
  - `redir_pc` = `RESET_PC`
  - `redir_kind` = 0
  - `redir_valid` = 0
  - `flush_*` = 0
  - `busy` = 0
  - State is IDLE and the counter is 0.
- Reset asserted mid-operation aborts any pending redirect and any flush immediately; nothing is replayed after reset.

## Timing
- A request sampled on edge N gives `redir_valid` = 1 from edge N to edge N+1. Latency is 1 cycle; there is no combinational request→output path.
- `redir_valid` stays high while `stall` = 1. Stall cycles are unbounded, and `redir_pc` remains stable except on a priority overwrite.
- Acceptance happens in the cycle `redir_valid && !stall`. Fetch loads `redir_pc` on that edge.
- After accepting a kind ≥ 1 redirect, `flush_*` are high for exactly `FLUSH_CYCLES` cycles, starting on the acceptance edge.
- Back-to-back branches with `stall` = 0 throughout give one redirect per cycle.

## Configuration
- `REDIRECT_STATS_EN`, when defined:
  - Adds output ports `stat_excp`, `stat_br` and `stat_stall`, each 16 bits.
  - Each counter saturates at 16'hffff.
  - `stat_excp` counts accepted redirects of kind ≥ 2. `stat_br` counts accepted redirects of kind 0. `stat_stall` counts ISSUE cycles with `stall` = 1.
  - All three reset to 0.
- When undefined: none of these ports exist, there is no counter logic, and the rest of the behaviour is identical.

## Structure
- Shared package `redirect_pkg` holds:
  - the `redir_kind_t` encoding (BR=0, ERET=1, EXC=2, REFILL=3);
  - the FSM state enum;
  - the default vector constants.
- One sub-module, `redirect_prio_enc`: combinational 4-request priority encoder that outputs the winning kind, a request-present flag, and the selected target.

## Test plan
- Branch in IDLE:
  - Stimulus: `br_taken` = 1, `br_target` = 32'h80001000 for 1 cycle, `stall` = 0.
  - Response: next cycle `redir_valid` = 1, `redir_pc` = 32'h80001000, `redir_kind` = 0. Then IDLE, and `flush_*` never rise.
- Simultaneous requests:
  - Stimulus: `excp` and `br_taken` together.
  - Response: `redir_pc` = 32'hbfc00380, kind 2. Then `flush_*` high for 2 cycles and `busy` low afterwards.
- Stall hold with preemption:
  - Stimulus: `eret` with `epc` = 32'h80002000, `stall` held for 5 cycles, `tlb_refill` pulsed in the third stall cycle.
  - Response: `redir_pc` switches to 32'hbfc00200 with kind 3, and it is accepted when `stall` drops.
- FLUSH filtering:
  - Stimulus: `br_taken` during FLUSH.
  - Response: ignored. `excp` during FLUSH gives ISSUE with `GEN_VEC` on the next edge.
- Reset mid-ISSUE:
  - Stimulus: assert `reset` asynchronously while a redirect is pending and stalled.
  - Response: outputs go to their reset values immediately, `redir_pc` = 32'hbfc00000, and no redirect appears after release.
- With `REDIRECT_STATS_EN` defined:
  - Stimulus: 3 branches, then 1 exception stalled for 4 cycles.
  - Response: `stat_br` = 3, `stat_excp` = 1, `stat_stall` = 4.
